// File: rtl/dtcctf_clkqual_pkg.sv
// Shared types and constants for the clock qualification / failover unit.
package dtcctf_clkqual_pkg;

  typedef enum logic [1:0] {
    ST_DOWN     = 2'd0,
    ST_SETTLE   = 2'd1,
    ST_LOCKWAIT = 2'd2,
    ST_QUAL     = 2'd3
  } ch_state_e;

  localparam int LOSS_W = 8;
  localparam int SEL_W  = 3;

endpackage

// File: rtl/dtcctf_clkqual_ch.sv
// One channel: qualification FSM, stability/timeout/loss counters, drift compare.
module dtcctf_clkqual_ch
  import dtcctf_clkqual_pkg::*;
#(
  parameter int W          = 16,
  parameter int STABLE_CNT = 2000,
  parameter int LOCK_TMO   = 4096,
  parameter int DRIFT_TOL  = 8
) (
  input  logic              clk0,
  input  logic              rst,
  input  logic [W-1:0]      meas_val_i,
  input  logic              meas_dv_i,
  input  logic              meas_ok_i,
  input  logic              pll_locked_i,
  input  logic              ch_enable_i,
  output logic              pll_rst_o,
  output logic              ch_ok_o,
  output logic [1:0]        ch_state_o,
  output logic [LOSS_W-1:0] loss_cnt_o
);

  localparam int SCW = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
  localparam int TCW = (LOCK_TMO > 1) ? $clog2(LOCK_TMO) : 1;

  ch_state_e         state_q, state_d;
  logic [SCW-1:0]    stab_q, stab_d;
  logic [TCW-1:0]    tmo_q, tmo_d;
  logic [W-1:0]      ref_q, ref_d;
  logic [LOSS_W-1:0] loss_q, loss_d;
  logic              pll_rst_q, ch_ok_q;

  logic signed [W:0] diff;
  logic [W:0]        abs_diff;
  logic              drift_bad;
  logic              bad_meas;

  // Both operands are zero-extended, so the W+1 bit signed difference never wraps.
  always_comb begin
    diff      = $signed({1'b0, meas_val_i}) - $signed({1'b0, ref_q});
    abs_diff  = diff[W] ? $unsigned(-diff) : $unsigned(diff);
    drift_bad = abs_diff > (W+1)'(DRIFT_TOL);
    bad_meas  = meas_dv_i && !meas_ok_i;
  end

  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    tmo_d   = tmo_q;
    ref_d   = ref_q;
    loss_d  = loss_q;
    if (!ch_enable_i) begin
      state_d = ST_DOWN;
    end else begin
      case (state_q)
        ST_DOWN: state_d = ST_SETTLE;
        ST_SETTLE: begin
          if (meas_dv_i) begin
            if (!meas_ok_i) begin
              stab_d = '0;
            end else if (stab_q == SCW'(STABLE_CNT - 1)) begin
              ref_d   = meas_val_i;
              state_d = ST_LOCKWAIT;
            end else begin
              stab_d = stab_q + 1'b1;
            end
          end
        end
        ST_LOCKWAIT: begin
          tmo_d = tmo_q + 1'b1;
          if (bad_meas || (tmo_q == TCW'(LOCK_TMO - 1))) state_d = ST_DOWN;
          else if (pll_locked_i)                          state_d = ST_QUAL;
        end
        ST_QUAL: begin
          if (!pll_locked_i || bad_meas || (meas_dv_i && drift_bad)) begin
            state_d = ST_DOWN;
            if (loss_q != '1) loss_d = loss_q + 1'b1;
          end
        end
        default: state_d = ST_DOWN;
      endcase
    end
    // Counters only live while their owning state is active.
    if (state_d != ST_SETTLE)   stab_d = '0;
    if (state_d != ST_LOCKWAIT) tmo_d  = '0;
  end

  always_ff @(posedge clk0 or posedge rst) begin
    if (rst) begin
      state_q   <= ST_DOWN;
      stab_q    <= '0;
      tmo_q     <= '0;
      ref_q     <= '0;
      loss_q    <= '0;
      pll_rst_q <= 1'b1;
      ch_ok_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      stab_q    <= stab_d;
      tmo_q     <= tmo_d;
      ref_q     <= ref_d;
      loss_q    <= loss_d;
      pll_rst_q <= (state_d == ST_DOWN) || (state_d == ST_SETTLE);
      ch_ok_q   <= (state_d == ST_QUAL);
    end
  end

  assign pll_rst_o  = pll_rst_q;
  assign ch_ok_o    = ch_ok_q;
  assign ch_state_o = state_q;
  assign loss_cnt_o = loss_q;

endmodule

// File: rtl/dtcctf_clkqual_multi.sv
// N-channel clock qualification with active-source selection.
// Define CLKQUAL_REVERTIVE_EN for revertive selection (default: sticky).
module dtcctf_clkqual_multi
  import dtcctf_clkqual_pkg::*;
#(
  parameter int NCH        = 4,
  parameter int W          = 16,
  parameter int STABLE_CNT = 2000,
  parameter int LOCK_TMO   = 4096,
  parameter int DRIFT_TOL  = 8
) (
  input  logic                    clk0,
  input  logic                    rst,
  input  logic [NCH*W-1:0]        meas_val,
  input  logic [NCH-1:0]          meas_dv,
  input  logic [NCH-1:0]          meas_ok,
  input  logic [NCH-1:0]          pll_locked,
  input  logic [NCH-1:0]          ch_enable,
  output logic [NCH-1:0]          pll_rst,
  output logic [NCH-1:0]          ch_ok,
  output logic [NCH*2-1:0]        ch_state,
  output logic [NCH*LOSS_W-1:0]   loss_cnt,
  output logic [SEL_W-1:0]        sel_ch,
  output logic                    sel_valid,
  output logic                    sel_switch
);

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    dtcctf_clkqual_ch #(
      .W(W), .STABLE_CNT(STABLE_CNT), .LOCK_TMO(LOCK_TMO), .DRIFT_TOL(DRIFT_TOL)
    ) u_ch (
      .clk0         (clk0),
      .rst          (rst),
      .meas_val_i   (meas_val[g*W +: W]),
      .meas_dv_i    (meas_dv[g]),
      .meas_ok_i    (meas_ok[g]),
      .pll_locked_i (pll_locked[g]),
      .ch_enable_i  (ch_enable[g]),
      .pll_rst_o    (pll_rst[g]),
      .ch_ok_o      (ch_ok[g]),
      .ch_state_o   (ch_state[g*2 +: 2]),
      .loss_cnt_o   (loss_cnt[g*LOSS_W +: LOSS_W])
    );
  end

  logic [SEL_W-1:0] sel_ch_q, sel_ch_d, low_idx;
  logic             sel_valid_q, sel_valid_d, sel_switch_q, sel_switch_d;
  logic             low_found;
`ifndef CLKQUAL_REVERTIVE_EN
  logic             cur_ok;
`endif

  // Selection works on the registered ch_ok, adding one cycle after the channel update.
  always_comb begin
    low_found = 1'b0;
    low_idx   = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (ch_ok[i]) begin
        low_found = 1'b1;
        low_idx   = SEL_W'(i);
      end
    end
    sel_ch_d    = sel_ch_q;
    sel_valid_d = 1'b0;
`ifdef CLKQUAL_REVERTIVE_EN
    if (low_found) begin
      sel_ch_d    = low_idx;
      sel_valid_d = 1'b1;
    end
`else
    cur_ok = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (ch_ok[i] && (SEL_W'(i) == sel_ch_q)) cur_ok = 1'b1;
    end
    if (cur_ok) begin
      sel_valid_d = 1'b1;
    end else if (low_found) begin
      sel_ch_d    = low_idx;
      sel_valid_d = 1'b1;
    end
`endif
    sel_switch_d = (sel_ch_d != sel_ch_q) || (sel_valid_d != sel_valid_q);
  end

  always_ff @(posedge clk0 or posedge rst) begin
    if (rst) begin
      sel_ch_q     <= '0;
      sel_valid_q  <= 1'b0;
      sel_switch_q <= 1'b0;
    end else begin
      sel_ch_q     <= sel_ch_d;
      sel_valid_q  <= sel_valid_d;
      sel_switch_q <= sel_switch_d;
    end
  end

  assign sel_ch     = sel_ch_q;
  assign sel_valid  = sel_valid_q;
  assign sel_switch = sel_switch_q;

endmodule

// File: doc/dtcctf_clkqual_multi.md
# dtcctf_clkqual_multi

N-channel clock qualification and failover unit. It consumes per-channel frequency measurements from `clock_measure` instances and runs one qualification state machine per channel, which drives that channel's PLL reset and tracks its lock. It then selects one qualified channel as the active clock source. It sits between the clock measurement front-ends and the clock mux / PLL bank, all in the `clk0` domain.

## Interface
Parameters:
- `NCH`, 4: number of monitored clock channels (1..8).
- `W`, 16: width of one measurement value.
- `STABLE_CNT`, 2000: consecutive in-range measurements required before releasing PLL reset (about 500 ms).
- `LOCK_TMO`, 4096: `clk0` cycles allowed for PLL lock after reset release.
- `DRIFT_TOL`, 8: maximum allowed |meas − reference| in counts while qualified.

Ports:
- `clk0`, in, 1: system clock; everything is synchronous to its rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `meas_val`, in, `NCH*W`: measurement of channel i, in bits `[i*W +: W]`.
- `meas_dv`, in, `NCH`: one-cycle strobe; the channel i value and flag are valid.
- `meas_ok`, in, `NCH`: in-range flag of the measurement (status bit 2), sampled with `meas_dv`.
- `pll_locked`, in, `NCH`: PLL lock of each channel, already synchronised to `clk0`.
- `ch_enable`, in, `NCH`: channel enable; low forces the channel to DOWN.
- `pll_rst`, out, `NCH`: PLL reset request per channel.
- `ch_ok`, out, `NCH`: channel is in QUAL.
- `ch_state`, out, `NCH*2`: state code per channel.
- `loss_cnt`, out, `NCH*8`: per-channel count of QUAL→DOWN events, saturating at 255.
- `sel_ch`, out, 3: index of the active channel.
- `sel_valid`, out, 1: `sel_ch` points at a channel in QUAL.
- `sel_switch`, out, 1: one-cycle pulse when `sel_ch` or `sel_valid` changes.

## Operation
Each channel has its own FSM with a 2-bit state code: DOWN=0, SETTLE=1, LOCKWAIT=2, QUAL=3.
- **DOWN**: `pll_rst`=1 and the counters are cleared. If `ch_enable` is set, go to SETTLE on the next cycle.
- **SETTLE**: `pll_rst`=1.
  - On `meas_dv` with `meas_ok`=0, clear `stab_cnt`.
  - On `meas_dv` with `meas_ok`=1, increment `stab_cnt`.
  - When `meas_dv` arrives with `meas_ok`=1 and `stab_cnt`==`STABLE_CNT`−1, latch `ref_val` = `meas_val` and go to LOCKWAIT.
- **LOCKWAIT**: `pll_rst`=0 and `tmo_cnt` increments every cycle.
  - `pll_locked`=1: go to QUAL.
  - `tmo_cnt`==`LOCK_TMO`−1, or `meas_dv` with `meas_ok`=0: go to DOWN.
- **QUAL**: `pll_rst`=0. Any of the following sends the channel to DOWN and increments `loss_cnt`:
  - `pll_locked`=0,
  - `meas_dv` with `meas_ok`=0,
  - `meas_dv` with |`meas_val`−`ref_val`| > `DRIFT_TOL`.
- Drift arithmetic: the difference is computed in W+1 bits, signed, then absolute value. There is no wrap-around; `ref_val` is not updated while in QUAL.
- `ch_enable`=0 in any state sends the channel to DOWN on the next cycle. This does not count as a loss.
- Precedence when events are simultaneous: disable > lock loss > bad measurement > drift > advance.

Selection:
- If the current channel is in QUAL, keep it.
- Otherwise select the lowest-index channel in QUAL.
- If no channel is in QUAL, `sel_valid`=0 and `sel_ch` holds its last value.

## Timing
- Reset values: `pll_rst`=all ones, `ch_ok`=0, `ch_state`=0 (DOWN), `loss_cnt`=0, `sel_ch`=0, `sel_valid`=0, `sel_switch`=0.
- All outputs are registered.
- A state change is visible 1 cycle after the triggering `meas_dv` or `pll_locked` sample.
- `sel_ch`, `sel_valid` and `sel_switch` follow 1 cycle after `ch_ok` changes, so failover latency is 2 cycles from the fault.
- `meas_dv` on several channels in the same cycle is handled independently per channel.
- Asserting `rst` mid-operation immediately forces every channel to DOWN and clears all counters.

## Configuration
- `CLKQUAL_REVERTIVE_EN` defined: selection is revertive. Whenever a lower-index channel enters QUAL, `sel_ch` moves to it one cycle later and `sel_switch` pulses.
- `CLKQUAL_REVERTIVE_EN` undefined: selection is sticky, as described under Operation. It moves only when the active channel leaves QUAL.

## Structure
- Package `dtcctf_clkqual_pkg` holds:
  - the state enum (DOWN, SETTLE, LOCKWAIT, QUAL) and its 2-bit codes,
  - the loss-counter width constant (8),
  - the `sel_ch` width constant (3).
- Sub-module `dtcctf_clkqual_ch` implements one channel's FSM, stability, timeout and loss counters, and drift compare.
- The top level instantiates `NCH` copies of `dtcctf_clkqual_ch` in a generate loop and adds the selector.

## Test plan
Run with `STABLE_CNT`=4 and `LOCK_TMO`=16.
- **Qualify**: channel 0 enabled, 4 `meas_dv` pulses with `meas_ok`=1 and `meas_val`=1000, then `pll_locked` raised 3 cycles later. Expect: `pll_rst[0]` falls 1 cycle after the 4th strobe, `ch_state[0]`=3 1 cycle after lock, then `sel_valid`=1, `sel_ch`=0, and a single `sel_switch` pulse.
- **Stability reset**: sequence ok, ok, bad, ok, ok, ok on channel 1. Expect: `pll_rst[1]` stays 1 until the 4th consecutive good strobe.
- **Lock timeout**: `pll_locked` held 0 after release. Expect: channel back in DOWN after exactly 16 cycles in LOCKWAIT, and `loss_cnt` unchanged.
- **Drift and failover**: channels 0 and 1 both in QUAL with `sel_ch`=0; channel 0 then receives `meas_val`=1009 against `ref_val`=1000. Expect: channel 0 goes to DOWN, `loss_cnt[0]`=1, and `sel_ch`=1 two cycles after the strobe. `meas_val`=1008 must not trip the drift check.
- **Revertive mode**: with `CLKQUAL_REVERTIVE_EN` defined, channel 0 requalifies while channel 1 is active. Expect: `sel_ch` returns to 0. Without the macro, `sel_ch` stays at 1.
- **Reset mid-operation**: assert `rst` while all channels are in QUAL. Expect: all outputs take their reset values asynchronously.
